// File: rtl/bitrev_pkg.sv
// Shared definitions for the bit-reversal streaming engine: mode encodings,
// engine state type and the word bit-reverse helper.
package bitrev_pkg;

  localparam logic [1:0] MODE_PASS   = 2'b00;
  localparam logic [1:0] MODE_BITREV = 2'b01;
  localparam logic [1:0] MODE_WREV   = 2'b10;
  localparam logic [1:0] MODE_BOTH   = 2'b11;

  localparam int unsigned REV_MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_OUT,
    ST_DONE
  } state_e;

  // Reverses the low `width` bits of w; callers size-cast the result back down.
  function automatic logic [REV_MAX_W-1:0] reverse_word(input logic [REV_MAX_W-1:0] w,
                                                        input int unsigned width);
    logic [REV_MAX_W-1:0] r;
    logic [5:0]           src;
    logic [5:0]           dst;
    r = '0;
    for (int unsigned i = 0; i < REV_MAX_W; i++) begin
      dst = 6'(i);
      src = 6'(width - 1 - i);
      if (i < width) r[dst] = w[src];
    end
    return r;
  endfunction

endpackage

// File: rtl/bitrev_stream_ram.sv
// Message buffer: one synchronous write port, one synchronous read port with
// read enable. Kept as a separate block so a vendor macro can replace it.
module stream_ram
  import bitrev_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bitrev_stream.sv
// Windowed streaming engine over a DEPTH-word buffer: emits each word of the
// window as passthrough, bit-reversed, word-order reversed, or both.
module bitrev_stream
  import bitrev_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [1:0]        mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [1:0]        mode_q, mode_d;
  logic              wr_err_q;

  logic              rev_bits, rev_order;
  logic              last_w;
  logic              ram_re;
  logic [ADDR_W-1:0] raddr_fwd, raddr_rev, raddr;
  logic [DATA_W-1:0] ram_rdata;
  logic [REV_MAX_W-1:0] rd_ext;
  logic [DATA_W-1:0] xform;

  stream_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_en && !busy),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .re_i    (ram_re),
    .raddr_i (raddr),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    rev_bits  = 1'b0;
    rev_order = 1'b0;
    case (mode_q)
      MODE_PASS:   ;
      MODE_BITREV: rev_bits = 1'b1;
      MODE_WREV:   rev_order = 1'b1;
      MODE_BOTH:   begin rev_bits = 1'b1; rev_order = 1'b1; end
      default:     ;
    endcase
  end

  // len == DEPTH has zero low bits, so the reverse address still wraps correctly.
  assign raddr_fwd = base_q + idx_q[ADDR_W-1:0];
  assign raddr_rev = base_q + len_q[ADDR_W-1:0] - ADDR_W'(1) - idx_q[ADDR_W-1:0];
  assign raddr     = rev_order ? raddr_rev : raddr_fwd;
  assign ram_re    = (state_q == ST_FETCH);
  assign last_w    = (idx_q == len_q - (ADDR_W+1)'(1));

  always_comb begin
    rd_ext = '0;
    rd_ext[DATA_W-1:0] = ram_rdata;
    xform = rev_bits ? DATA_W'(reverse_word(rd_ext, DATA_W)) : ram_rdata;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    base_d  = base_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d  = start_addr;
          mode_d  = mode;
          idx_d   = '0;
          len_d   = (length > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : length;
          state_d = (length == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_OUT;
      ST_OUT: begin
        if (out_ready) begin
          if (last_w) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + (ADDR_W+1)'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      base_q   <= '0;
      mode_q   <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      base_q   <= base_d;
      mode_q   <= mode_d;
      wr_err_q <= wr_en && busy;
    end
  end

  // The RAM read register is the output register; it only reloads in FETCH,
  // so out_data holds through a stall and is forced to zero outside OUT.
  assign out_valid = (state_q == ST_OUT);
  assign out_last  = out_valid && last_w;
  assign out_data  = out_valid ? xform : '0;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_bitrev_stream.sv
// Scoreboard bench for bitrev_stream: directed windows push expected words,
// a negedge monitor pops and compares every transfer and done pulse.
module tb_bitrev_stream;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_err;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   length;
  logic [1:0]        mode;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  bitrev_stream #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_err     (wr_err),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int unsigned cyc      = 0;
  int          fire_cnt = 0;
  int          done_cnt = 0;
  int          exp_done = 0;
  int unsigned start_cyc     = 0;
  int unsigned last_fire_cyc = 0;
  bit          first_pending = 0;
  bit          exp_zero      = 0;
  bit          prev_done     = 0;
  bit          prev_stall    = 0;
  logic [8:0]  held;
  logic [8:0]  mon_exp;
  logic [8:0]  sb [$];
  logic [7:0]  img [DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) chk("stall_hold", 32'({out_valid, out_last, out_data}), 32'({1'b1, held}));
      prev_stall = out_valid && !out_ready;
      held = {out_last, out_data};
      if (start && !busy) begin
        start_cyc     = cyc;
        first_pending = 1'b1;
      end
      if (out_valid && first_pending) begin
        chk("first_latency", cyc, start_cyc + 2);
        first_pending = 1'b0;
      end
      if (out_valid && out_ready) begin
        fire_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_valid", 32'(out_valid), 32'(0));
        end else begin
          mon_exp = sb.pop_front();
          chk("out_word", 32'({out_last, out_data}), 32'(mon_exp));
          if (mon_exp[8]) last_fire_cyc = cyc;
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_cycle", cyc, exp_zero ? start_cyc + 1 : last_fire_cyc + 1);
        chk("done_width", 32'(prev_done), 32'(0));
      end
      prev_done = done;
    end else begin
      prev_stall    = 1'b0;
      prev_done     = 1'b0;
      first_pending = 1'b0;
    end
  end

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    img[a]  = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic last);
    sb.push_back({last, d});
  endtask

  task automatic start_win(input logic [ADDR_W-1:0] sa, input logic [ADDR_W:0] ln,
                           input logic [1:0] md);
    exp_done++;
    start_addr = sa;
    length     = ln;
    mode       = md;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble window inputs; the engine must have latched its own copies.
    start_addr = sa + 4'd7;
    length     = 5'd1;
    mode       = ~md;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (!busy && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_reached", 32'(ok), 32'(1));
    chk("done_count", 32'(done_cnt), 32'(exp_done));
  endtask

  task automatic wait_fires(input int target);
    bit ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (fire_cnt >= target) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("fire_wait", 32'(ok), 32'(1));
  endtask

  task automatic run(input logic [ADDR_W-1:0] sa, input logic [ADDR_W:0] ln, input logic [1:0] md);
    start_win(sa, ln, md);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; start_addr = '0; length = '0; mode = '0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_outputs", 32'({out_valid, out_last, busy, done, wr_err, out_data}), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < int'(DEPTH); i++) wr(4'(i), 8'(i * 17 + 5));
    wr(4'd0, 8'h01); wr(4'd1, 8'hB4); wr(4'd2, 8'hF0); wr(4'd3, 8'h3C);

    push(8'h80, 0); push(8'h2D, 0); push(8'h0F, 0); push(8'h3C, 1);
    run(4'd0, 5'd4, 2'b01);
    push(8'h3C, 0); push(8'hF0, 0); push(8'hB4, 0); push(8'h01, 1);
    run(4'd0, 5'd4, 2'b10);
    push(8'h3C, 0); push(8'h0F, 0); push(8'h2D, 0); push(8'h80, 1);
    run(4'd0, 5'd4, 2'b11);
    push(8'h01, 0); push(8'hB4, 0); push(8'hF0, 0); push(8'h3C, 1);
    run(4'd0, 5'd4, 2'b00);

    wr(4'd14, 8'hAA); wr(4'd15, 8'hBB); wr(4'd0, 8'hCC); wr(4'd1, 8'hDD);
    push(8'hDD, 0); push(8'hCC, 0); push(8'hBB, 0); push(8'hAA, 1);
    run(4'd14, 5'd4, 2'b10);

    push(8'hCC, 0); push(8'hDD, 0); push(8'hF0, 0); push(8'h3C, 1);
    base = fire_cnt;
    start_win(4'd0, 5'd4, 2'b00);
    wait_fires(base + 1);
    out_ready = 1'b0;
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h55;
    @(posedge clk); #1;
    chk("wr_err_pulse", 32'(wr_err), 32'(1));
    wr_en = 1'b0;
    @(posedge clk); #1;
    chk("wr_err_clear", 32'(wr_err), 32'(0));
    repeat (3) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    wait_idle();
    push(8'hCC, 0); push(8'hDD, 0); push(8'hF0, 0); push(8'h3C, 1);
    run(4'd0, 5'd4, 2'b00);

    exp_zero = 1'b1;
    run(4'd0, 5'd0, 2'b01);
    exp_zero = 1'b0;

    for (int i = 0; i < int'(DEPTH); i++) push(img[i], i == int'(DEPTH) - 1);
    run(4'd0, 5'd20, 2'b00);

    push(8'h33, 0); push(8'hBB, 0); push(8'h0F, 0); push(8'h3C, 1);
    base = fire_cnt;
    start_win(4'd0, 5'd4, 2'b01);
    wait_fires(base + 2);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_outputs", 32'({out_valid, out_last, busy, done, wr_err, out_data}), 32'(0));
    sb.delete();
    exp_done--;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midreset_no_done", 32'(done_cnt), 32'(exp_done));
    push(8'h0F, 1);
    run(4'd2, 5'd1, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
